seq_mag_compare: RTL and testbench

//  Digit-serial magnitude comparator: the parametrised successor of the 4-bit cascadable comparator.
//  - Compares two WIDTH-bit operands, DIGIT bits per clock, most-significant digit first.
//  - Terminates early on the first unequal digit.
//  - Supports unsigned and two's-complement (signed) modes.
//  - Used where wide compares must share one small comparator slice under a start/done handshake.

---
 rtl/seq_mag_compare.sv | 139 +++++++++++++
 tb/tb_seq_mag_compare.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_compare.sv
// -----------------------------------------------------------------------------
// seq_mag_compare
//   Digit-serial magnitude comparator. Compares two WIDTH-bit operands DIGIT
//   bits per clock, most-significant digit first, and stops on the first
//   unequal digit. Unsigned or two's-complement mode, start/done handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request, accepted only while busy==0
//   a, b         operands, sampled on the accepting edge
//   signed_mode  1: two's-complement compare (ignored when SIGNED_EN==0)
//   busy         high while a compare is in progress
//   done         one-cycle pulse when alb/agb/aeqb take a new result
//   alb/agb/aeqb A<B / A>B / A==B, exactly one high at all times
// -----------------------------------------------------------------------------
module seq_mag_compare #(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             agb,
  output logic             aeqb
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIGIT-1:0] TOP_MASK = DIGIT'(1) << (DIGIT - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : gBadParam
      $error("seq_mag_compare: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             modeSigned;

  // idx counts digits already scanned, so idx==0 selects the MS digit.
  function automatic logic [DIGIT-1:0] getDigit(input logic [WIDTH-1:0] v,
                                                input logic [IDX_W-1:0] pos);
    logic [DIGIT-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (pos == IDX_W'(NDIG - 1 - i)) r = v[i*DIGIT +: DIGIT];
    end
    return r;
  endfunction

  // Returns {gt, lt} for an unsigned digit compare.
  function automatic logic [1:0] cmpDigit(input logic [DIGIT-1:0] x,
                                          input logic [DIGIT-1:0] y);
    return {(x > y), (x < y)};
  endfunction

  logic [DIGIT-1:0] dA;
  logic [DIGIT-1:0] dB;
  logic [DIGIT-1:0] flip;
  logic [1:0]       gtLt;
  logic             lastDigit;

  // Inverting the sign bit of the MS digit maps two's-complement order onto
  // unsigned order; lower digits compare unsigned in either mode.
  always_comb begin
    flip      = (modeSigned && idx == '0) ? TOP_MASK : '0;
    dA        = getDigit(opA, idx) ^ flip;
    dB        = getDigit(opB, idx) ^ flip;
    gtLt      = cmpDigit(dA, dB);
    lastDigit = (idx == IDX_W'(NDIG - 1));
  end

  // Operand capture: data path, not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      opA        <= a;
      opB        <= b;
      modeSigned <= signed_mode && SIGNED_EN;
    end
  end

  // Control FSM with registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      alb   <= 1'b0;
      agb   <= 1'b0;
      aeqb  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (gtLt != 2'b00) begin
            alb   <= gtLt[0];
            agb   <= gtLt[1];
            aeqb  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (lastDigit) begin
            alb   <= 1'b0;
            agb   <= 1'b0;
            aeqb  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_compare
//   Directed and randomized bench for seq_mag_compare. Three instances:
//   16/4 signed-enabled, 16/4 signed-disabled (same inputs), 32/8 signed.
//   Expected results come from a plain integer compare model and a
//   first-differing-digit latency model.
// -----------------------------------------------------------------------------
module tb_seq_mag_compare;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start32;
  logic [31:0] aBus, bBus;
  logic        modeBus;

  logic busy16, done16, alb16, agb16, aeqb16;
  logic busyN,  doneN,  albN,  agbN,  aeqbN;
  logic busy32, done32, alb32, agb32, aeqb32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mag_compare #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(aBus[15:0]), .b(bBus[15:0]),
    .signed_mode(modeBus), .busy(busy16), .done(done16),
    .alb(alb16), .agb(agb16), .aeqb(aeqb16));

  seq_mag_compare #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1'b0)) dutN (
    .clk(clk), .rst(rst), .start(start16), .a(aBus[15:0]), .b(bBus[15:0]),
    .signed_mode(modeBus), .busy(busyN), .done(doneN),
    .alb(albN), .agb(agbN), .aeqb(aeqbN));

  seq_mag_compare #(.WIDTH(32), .DIGIT(8), .SIGNED_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(aBus), .b(bBus),
    .signed_mode(modeBus), .busy(busy32), .done(done32),
    .alb(alb32), .agb(agb32), .aeqb(aeqb32));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: compare as plain integers. Returns {agb,alb,aeqb}.
  function automatic logic [2:0] expRes(input logic [31:0] av, input logic [31:0] bv,
                                        input bit sm, input bit wide);
    longint x, y;
    if (wide) begin
      x = sm ? longint'($signed(av)) : longint'(av);
      y = sm ? longint'($signed(bv)) : longint'(bv);
    end else begin
      x = sm ? longint'($signed(av[15:0])) : longint'(av[15:0]);
      y = sm ? longint'($signed(bv[15:0])) : longint'(bv[15:0]);
    end
    if (x < y) return 3'b010;
    if (x > y) return 3'b100;
    return 3'b001;
  endfunction

  // Expected edges from accept to done: first unequal digit + 1, or NDIG.
  function automatic int expLat(input logic [31:0] av, input logic [31:0] bv,
                                input int nd, input int dw);
    logic [31:0] diff;
    logic [31:0] mask;
    diff = av ^ bv;
    mask = (32'd1 << dw) - 32'd1;
    for (int k = 0; k < nd; k++) begin
      if (((diff >> ((nd - 1 - k) * dw)) & mask) != 0) return k + 1;
    end
    return nd;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge,
  // with the operand buses scrambled to prove the DUT latched them.
  task automatic startOp(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                         input bit sm);
    aBus    = av;
    bBus    = bv;
    modeBus = sm;
    if (wide) start32 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    start32 = 1'b0;
    aBus    = $urandom;
    bBus    = $urandom;
    modeBus = $urandom_range(0, 1);
  endtask

  // Counts edges until done, checking one-hot outputs and busy every cycle.
  task automatic waitDone(input bit wide, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk);
      @(negedge clk);
      lat = n;
      if (wide) begin
        check("onehot32", 32'($countones({alb32, agb32, aeqb32})), 32'd1);
        check("busy32", 32'(busy32), 32'(!done32));
        got = done32;
      end else begin
        check("onehot16", 32'($countones({alb16, agb16, aeqb16})), 32'd1);
        check("onehotN", 32'($countones({albN, agbN, aeqbN})), 32'd1);
        check("busy16", 32'(busy16), 32'(!done16));
        got = done16;
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      lat = -1;
    end
  endtask

  task automatic runOp(input bit wide, input logic [31:0] av0, input logic [31:0] bv0,
                       input bit sm);
    logic [31:0] av, bv;
    int lat;
    av = wide ? av0 : {16'h0, av0[15:0]};
    bv = wide ? bv0 : {16'h0, bv0[15:0]};
    startOp(wide, av, bv, sm);
    waitDone(wide, lat);
    if (wide) begin
      check("lat32", 32'(lat), 32'(expLat(av, bv, 4, 8)));
      check("res32", 32'({agb32, alb32, aeqb32}), 32'(expRes(av, bv, sm, 1'b1)));
    end else begin
      check("lat16", 32'(lat), 32'(expLat(av, bv, 4, 4)));
      check("res16", 32'({agb16, alb16, aeqb16}), 32'(expRes(av, bv, sm, 1'b0)));
      check("resN", 32'({agbN, albN, aeqbN}), 32'(expRes(av, bv, 1'b0, 1'b0)));
      check("doneN", 32'(doneN), 32'd1);
    end
  endtask

  function automatic logic [31:0] mkB(input logic [31:0] av, input int nd, input int dw);
    logic [31:0] keep;
    int r;
    if ($urandom_range(0, 4) == 0) return $urandom;
    r = $urandom_range(0, nd);
    keep = (r == 0) ? 32'h0 : ~((32'd1 << ((nd - r) * dw)) - 32'd1);
    if (r == nd) keep = 32'hFFFF_FFFF;
    return (av & keep) | ($urandom & ~keep);
  endfunction

  initial begin
    int lat, lat2;
    logic [31:0] av;
    rst = 1'b1; start16 = 1'b0; start32 = 1'b0;
    aBus = '0; bBus = '0; modeBus = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'({busy16, busyN, busy32}), 32'd0);
    check("rst_done", 32'({done16, doneN, done32}), 32'd0);
    check("rst_res16", 32'({agb16, alb16, aeqb16}), 32'd1);
    check("rst_resN", 32'({agbN, albN, aeqbN}), 32'd1);
    check("rst_res32", 32'({agb32, alb32, aeqb32}), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    runOp(1'b0, 32'h1234, 32'h1235, 1'b0);
    check("t1_alb", 32'(alb16), 32'd1);
    runOp(1'b0, 32'h8000, 32'h7FFF, 1'b0);
    check("t2_agb_u", 32'(agb16), 32'd1);
    runOp(1'b0, 32'h8000, 32'h7FFF, 1'b1);
    check("t2_alb_s", 32'(alb16), 32'd1);
    check("t2_agb_nosigned", 32'(agbN), 32'd1);
    runOp(1'b0, 32'hABCD, 32'hABCD, 1'b0);
    check("t3_eq", 32'(aeqb16), 32'd1);
    runOp(1'b0, 32'hFFFF, 32'hFFFE, 1'b1);
    check("t3_agb_s", 32'(agb16), 32'd1);

    // Start while busy is ignored; start in the done cycle is accepted.
    startOp(1'b0, 32'h0001, 32'h0000, 1'b0);
    aBus = 32'hF000; bBus = 32'h0000; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    waitDone(1'b0, lat);
    check("t4_lat", 32'(lat + 1), 32'd4);
    check("t4_agb", 32'({agb16, alb16, aeqb16}), 32'b100);
    startOp(1'b0, 32'h0000, 32'h0100, 1'b0);
    waitDone(1'b0, lat2);
    check("t4_b2b_lat", 32'(lat2), 32'd2);
    check("t4_b2b_alb", 32'({agb16, alb16, aeqb16}), 32'b010);

    // Reset mid-scan abandons the operation.
    startOp(1'b0, 32'h1234, 32'h1234, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy16), 32'd0);
    check("t5_done", 32'(done16), 32'd0);
    check("t5_res", 32'({agb16, alb16, aeqb16}), 32'b001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_nodone", 32'({done16, busy16}), 32'd0);
    end

    // Random sweeps.
    for (int i = 0; i < 400; i++) begin
      av = {16'h0, 16'($urandom)};
      runOp(1'b0, av, mkB(av, 4, 4), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 10000; i++) begin
      av = $urandom;
      runOp(1'b1, av, mkB(av, 4, 8), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
